// File: rtl/i_mem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words
// and writes them into instruction memory while holding the core.
// Optional trailing XOR checksum byte: define I_MEM_LOADER_CHECKSUM_EN.
module i_mem_loader #(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                   MAX_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          load_len,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [BUS_WIDTH-1:0] i_mem_address,
    output logic                 i_mem_wr_en,
    output logic [BUS_WIDTH-1:0] i_mem_wr_data,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
`ifdef I_MEM_LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] word_idx;
    logic [15:0] word_next;
    logic [1:0]  byte_idx;
    logic [23:0] pack_q;
    logic        error_q;
    logic        accept;
    logic        start_ok;
    logic        too_long;
`ifdef I_MEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept    = byte_valid & byte_ready;
    assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));
    assign too_long  = {1'b0, load_len} > MAX_LEN;
    assign word_next = word_idx + 16'd1;
    assign core_hold = busy;
    assign done      = (state_q == DONE);
    assign error     = error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_ready  = 1'b0;
        busy        = 1'b0;
        i_mem_wr_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (load_len == 16'd0 || too_long) begin
                        state_d = DONE;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept && byte_idx == 2'd3) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                i_mem_wr_en = 1'b1;
                if (word_next < len_q) begin
                    state_d = RECV;
                end else begin
`ifdef I_MEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef I_MEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the address/data registers load when the fourth byte lands, so they are
    // valid throughout WRITE and simply hold their value afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q         <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            pack_q        <= '0;
            error_q       <= 1'b0;
            i_mem_address <= '0;
            i_mem_wr_data <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            if (start_ok) begin
                len_q    <= load_len;
                word_idx <= '0;
                byte_idx <= '0;
                error_q  <= too_long;
`ifdef I_MEM_LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end
            if (state_q == RECV && accept) begin
                byte_idx <= byte_idx + 2'd1;
`ifdef I_MEM_LOADER_CHECKSUM_EN
                csum_q   <= csum_q ^ byte_in;
`endif
                case (byte_idx)
                    2'd0: pack_q[7:0]   <= byte_in;
                    2'd1: pack_q[15:8]  <= byte_in;
                    2'd2: pack_q[23:16] <= byte_in;
                    default: begin
                        i_mem_wr_data <= {byte_in, pack_q};
                        i_mem_address <= BASE_ADDR + (BUS_WIDTH'(word_idx) << 2);
                    end
                endcase
            end
            if (state_q == WRITE) begin
                word_idx <= word_next;
            end
`ifdef I_MEM_LOADER_CHECKSUM_EN
            if (state_q == CHECK && accept) begin
                error_q <= (byte_in != csum_q);
            end
`endif
        end
    end

endmodule

// File: tb/tb_i_mem_loader.sv
// Directed testbench for i_mem_loader: reset, packing, backpressure, length edges,
// restart, and (when I_MEM_LOADER_CHECKSUM_EN is defined) the trailing checksum.
module tb_i_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] i_mem_address;
    logic        i_mem_wr_en;
    logic [31:0] i_mem_wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int wr_base;

    i_mem_loader #(
        .BUS_WIDTH (32),
        .BASE_ADDR (32'h0),
        .MAX_WORDS (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_len      (load_len),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .i_mem_address (i_mem_address),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_wr_data (i_mem_wr_data),
        .core_hold     (core_hold),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_mem_wr_en) wr_count <= wr_count + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] len);
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start    = 1'b0;
        load_len = 16'hFFFF;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) checkOutput("ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic finishImage(input logic [7:0] csum);
`ifdef I_MEM_LOADER_CHECKSUM_EN
        checkOutput("check_hold", 32'(core_hold), 32'd1);
        sendByte(csum);
`else
        if (csum == 8'hxx) $display("[TB] unreachable");
`endif
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        load_len   = 16'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_outputs", {26'd0, byte_ready, i_mem_wr_en, core_hold, busy, done, error}, 32'd0);
        checkOutput("rst_addr", i_mem_address, 32'd0);
        checkOutput("rst_data", i_mem_wr_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Async reset mid-RECV
        applyStimulus(16'd2);
        checkOutput("recv_flags", {29'd0, byte_ready, busy, core_hold}, 32'h7);
        sendByte(8'h78);
        sendByte(8'h56);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst", {27'd0, byte_ready, i_mem_wr_en, core_hold, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_rst", {30'd0, byte_ready, busy}, 32'd0);

        // Basic two-word load
        wr_base = wr_count;
        applyStimulus(16'd2);
        sendByte(8'h78); sendByte(8'h56); sendByte(8'h34); sendByte(8'h12);
        checkOutput("w0_wr_en", 32'(i_mem_wr_en), 32'd1);
        checkOutput("w0_addr", i_mem_address, 32'h0000_0000);
        checkOutput("w0_data", i_mem_wr_data, 32'h1234_5678);
        checkOutput("w0_ready_low", 32'(byte_ready), 32'd0);
        sendByte(8'hEF); sendByte(8'hBE); sendByte(8'hAD); sendByte(8'hDE);
        checkOutput("w1_wr_en", 32'(i_mem_wr_en), 32'd1);
        checkOutput("w1_addr", i_mem_address, 32'h0000_0004);
        checkOutput("w1_data", i_mem_wr_data, 32'hDEAD_BEEF);
        @(negedge clk);
        finishImage(8'h2A);
        checkOutput("basic_status", {28'd0, done, error, core_hold, busy}, 32'h8);
        checkOutput("basic_wr_count", 32'(wr_count - wr_base), 32'd2);
        checkOutput("addr_held", i_mem_address, 32'h0000_0004);

        // Backpressure: valid toggles every cycle
        wr_base = wr_count;
        applyStimulus(16'd1);
        sendByte(8'h78); @(negedge clk);
        sendByte(8'h56); @(negedge clk);
        sendByte(8'h34); @(negedge clk);
        checkOutput("bp_no_early_write", 32'(wr_count - wr_base), 32'd0);
        sendByte(8'h12);
        checkOutput("bp_data", i_mem_wr_data, 32'h1234_5678);
        checkOutput("bp_addr", i_mem_address, 32'h0000_0000);
        @(negedge clk);
        finishImage(8'h08);
        @(negedge clk);
        checkOutput("bp_wr_count", 32'(wr_count - wr_base), 32'd1);
        checkOutput("bp_done", {30'd0, done, error}, 32'h2);

        // Zero length
        wr_base = wr_count;
        applyStimulus(16'd0);
        checkOutput("len0_status", {28'd0, done, error, busy, byte_ready}, 32'h8);
        @(negedge clk);
        checkOutput("len0_wr_count", 32'(wr_count - wr_base), 32'd0);

        // Oversize
        applyStimulus(16'd1025);
        checkOutput("len_big_status", {28'd0, done, error, busy, byte_ready}, 32'hC);
        @(negedge clk);
        checkOutput("len_big_wr_count", 32'(wr_count - wr_base), 32'd0);

        // MAX_WORDS exactly is accepted
        applyStimulus(16'd1024);
        checkOutput("len_max_accept", {29'd0, done, error, busy}, 32'h1);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Restart from DONE with an error flag, start ignored mid-load
        applyStimulus(16'd1025);
        checkOutput("pre_restart_err", 32'(error), 32'd1);
        wr_base = wr_count;
        applyStimulus(16'd1);
        checkOutput("restart_clear", {29'd0, done, error, busy}, 32'h1);
        sendByte(8'hA1); sendByte(8'hB2);
        applyStimulus(16'd5);
        checkOutput("start_ignored", 32'(busy), 32'd1);
        sendByte(8'hC3); sendByte(8'hD4);
        checkOutput("restart_addr", i_mem_address, 32'h0000_0000);
        checkOutput("restart_data", i_mem_wr_data, 32'hD4C3_B2A1);
        @(negedge clk);
        finishImage(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
        checkOutput("restart_done", {30'd0, done, error}, 32'h2);
        checkOutput("restart_wr_count", 32'(wr_count - wr_base), 32'd1);

`ifdef I_MEM_LOADER_CHECKSUM_EN
        applyStimulus(16'd1);
        sendByte(8'h78); sendByte(8'h56); sendByte(8'h34); sendByte(8'h12);
        @(negedge clk);
        sendByte(8'h09);
        checkOutput("csum_bad", {30'd0, done, error}, 32'h3);
        applyStimulus(16'd1);
        sendByte(8'h78); sendByte(8'h56); sendByte(8'h34); sendByte(8'h12);
        @(negedge clk);
        sendByte(8'h08);
        checkOutput("csum_good", {30'd0, done, error}, 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
